// File: rtl/dh_pkg.sv
// rtl/dh_pkg.sv - shared constants, index-width helper and output-FSM encoding for the Dh min selector
package dh_pkg;

    localparam int Q = 8;                      // fractional bits of Dh, carried through untouched
    localparam int N = 16;                     // Dh word width, signed
    localparam logic [N-1:0] SAT_MAX = 16'h7FFF;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Width of a candidate index; never below 1 bit so tiny frames still elaborate.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dh_top2_insert.sv
// rtl/dh_top2_insert.sv - combinational insertion of one sample into a running smallest/second-smallest pair
//
// Ports:
//   first         in  1      sample is the first of a frame (restarts the pair)
//   x             in  N      conditioned sample value (non-negative)
//   cnt           in  IDX_W  candidate index of x
//   cur_min*      in         current smallest value / index
//   cur_min2*     in         current second-smallest value / index
//   nxt_min*      out        updated smallest value / index
//   nxt_min2*     out        updated second-smallest value / index
module dh_top2_insert #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic             first,
    input  logic [N-1:0]     x,
    input  logic [IDX_W-1:0] cnt,
    input  logic [N-1:0]     cur_min,
    input  logic [IDX_W-1:0] cur_min_idx,
    input  logic [N-1:0]     cur_min2,
    input  logic [IDX_W-1:0] cur_min2_idx,
    output logic [N-1:0]     nxt_min,
    output logic [IDX_W-1:0] nxt_min_idx,
    output logic [N-1:0]     nxt_min2,
    output logic [IDX_W-1:0] nxt_min2_idx
);

    localparam logic [N-1:0] SAT = {1'b0, {(N-1){1'b1}}};

    always_comb begin
        nxt_min      = cur_min;
        nxt_min_idx  = cur_min_idx;
        nxt_min2     = cur_min2;
        nxt_min2_idx = cur_min2_idx;
        if (first) begin
            nxt_min      = x;
            nxt_min_idx  = '0;
            nxt_min2     = SAT;
            nxt_min2_idx = '0;
        end else if ($signed(x) < $signed(cur_min)) begin
            nxt_min2     = cur_min;
            nxt_min2_idx = cur_min_idx;
            nxt_min      = x;
            nxt_min_idx  = cnt;
        end else if ($signed(x) < $signed(cur_min2)) begin
            // Strict compares: an equal value never displaces, so the lower index keeps its slot.
            nxt_min2     = x;
            nxt_min2_idx = cnt;
        end
    end

endmodule

// File: rtl/dh_min_sel.sv
// rtl/dh_min_sel.sv - per-frame smallest/second-smallest Dh tracker with a one-deep valid/ready result register
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   frame_clear   abort partial frame, candidate index restarts at 0
//   Dh_valid/Dh_in  one Dh sample per pulse, no backpressure
//   res_ready     downstream accepts the result
//   res_valid     result registers hold an unaccepted frame result
//   min_val/min_idx, min2_val/min2_idx  frame result
//   res_ovf       sticky: a completed frame was dropped
//   busy          partial frame in progress
module dh_min_sel
    import dh_pkg::*;
#(
    parameter int N        = dh_pkg::N,
    parameter int NUM_CAND = 16,
    localparam int IDX_W   = idx_w(NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_clear,
    input  logic             Dh_valid,
    input  logic [N-1:0]     Dh_in,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [N-1:0]     min_val,
    output logic [IDX_W-1:0] min_idx,
    output logic [N-1:0]     min2_val,
    output logic [IDX_W-1:0] min2_idx,
    output logic             res_ovf,
    output logic             busy
);

    localparam logic [N-1:0]     SAT      = {1'b0, {(N-1){1'b1}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    logic [IDX_W-1:0] cand_cnt;
    logic [N-1:0]     w_min, w_min2;
    logic [IDX_W-1:0] w_min_idx, w_min2_idx;
    out_state_t       state;

    logic [N-1:0]     x;
    logic             sample;
    logic             frame_end;
    logic [N-1:0]     n_min, n_min2;
    logic [IDX_W-1:0] n_min_idx, n_min2_idx;

    // A negative Dh means the upstream accumulator wrapped; treat it as the largest value.
    assign x         = Dh_in[N-1] ? SAT : Dh_in;
    assign sample    = Dh_valid && !frame_clear;
    assign frame_end = sample && (cand_cnt == LAST_IDX);

    assign res_valid = (state == FULL);
    assign busy      = (cand_cnt != '0);

    dh_top2_insert #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_insert (
        .first        (cand_cnt == '0),
        .x            (x),
        .cnt          (cand_cnt),
        .cur_min      (w_min),
        .cur_min_idx  (w_min_idx),
        .cur_min2     (w_min2),
        .cur_min2_idx (w_min2_idx),
        .nxt_min      (n_min),
        .nxt_min_idx  (n_min_idx),
        .nxt_min2     (n_min2),
        .nxt_min2_idx (n_min2_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_cnt   <= '0;
            w_min      <= SAT;
            w_min_idx  <= '0;
            w_min2     <= SAT;
            w_min2_idx <= '0;
        end else if (frame_clear) begin
            cand_cnt   <= '0;
            w_min      <= SAT;
            w_min_idx  <= '0;
            w_min2     <= SAT;
            w_min2_idx <= '0;
        end else if (Dh_valid) begin
            cand_cnt   <= (cand_cnt == LAST_IDX) ? '0 : cand_cnt + 1'b1;
            w_min      <= n_min;
            w_min_idx  <= n_min_idx;
            w_min2     <= n_min2;
            w_min2_idx <= n_min2_idx;
        end
    end

    // Output register and its EMPTY/FULL state; loads the post-update pair of the final sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            min_val  <= '0;
            min_idx  <= '0;
            min2_val <= '0;
            min2_idx <= '0;
            res_ovf  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (frame_end) begin
                        state    <= FULL;
                        min_val  <= n_min;
                        min_idx  <= n_min_idx;
                        min2_val <= n_min2;
                        min2_idx <= n_min2_idx;
                    end
                end
                FULL: begin
                    if (frame_end) begin
                        if (res_ready) begin
                            min_val  <= n_min;
                            min_idx  <= n_min_idx;
                            min2_val <= n_min2;
                            min2_idx <= n_min2_idx;
                        end else begin
                            res_ovf  <= 1'b1;
                        end
                    end else if (res_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_dh_min_sel.sv
// tb/tb_dh_min_sel.sv - directed and scoreboard checks of dh_min_sel (4- and 16-candidate instances)
module tb_dh_min_sel;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // NUM_CAND = 4 instance
    logic        clr4 = 1'b0, dv4 = 1'b0, rdy4 = 1'b0;
    logic [15:0] din4 = '0;
    logic        rv4, ovf4, busy4;
    logic [15:0] mv4, m2v4;
    logic [1:0]  mi4, m2i4;

    // NUM_CAND = 16 instance
    logic        clr16 = 1'b0, dv16 = 1'b0, rdy16 = 1'b1;
    logic [15:0] din16 = '0;
    logic        rv16, ovf16, busy16;
    logic [15:0] mv16, m2v16;
    logic [3:0]  mi16, m2i16;

    dh_min_sel #(.N(16), .NUM_CAND(4)) dut4 (
        .clk(clk), .rst(rst), .frame_clear(clr4), .Dh_valid(dv4), .Dh_in(din4),
        .res_ready(rdy4), .res_valid(rv4), .min_val(mv4), .min_idx(mi4),
        .min2_val(m2v4), .min2_idx(m2i4), .res_ovf(ovf4), .busy(busy4)
    );

    dh_min_sel #(.N(16), .NUM_CAND(16)) dut16 (
        .clk(clk), .rst(rst), .frame_clear(clr16), .Dh_valid(dv16), .Dh_in(din16),
        .res_ready(rdy16), .res_valid(rv16), .min_val(mv16), .min_idx(mi16),
        .min2_val(m2v16), .min2_idx(m2i16), .res_ovf(ovf16), .busy(busy16)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [15:0] v);
        dv4 = 1'b1; din4 = v;
        tick();
        dv4 = 1'b0;
    endtask

    task automatic frame4(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
        send4(a); send4(b); send4(c); send4(d);
    endtask

    task automatic check_res4(input string tag, input logic [15:0] m, input logic [1:0] mi,
                              input logic [15:0] m2, input logic [1:0] m2i);
        check({tag, ".valid"}, rv4, 1);
        check({tag, ".min"}, mv4, m);
        check({tag, ".min_idx"}, mi4, mi);
        check({tag, ".min2"}, m2v4, m2);
        check({tag, ".min2_idx"}, m2i4, m2i);
    endtask

    task automatic accept4();
        rdy4 = 1'b1;
        tick();
        rdy4 = 1'b0;
    endtask

    logic [15:0] rv_vals [16];
    logic [15:0] cond;
    int          bi, si;

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst.valid", rv4, 0);
        check("rst.min", mv4, 0);
        check("rst.min2", m2v4, 0);
        check("rst.ovf", ovf4, 0);
        check("rst.busy", busy4, 0);

        // Ties: lower index keeps the slot
        frame4(16'h0300, 16'h0100, 16'h0200, 16'h0100);
        check_res4("tie", 16'h0100, 2'd1, 16'h0100, 2'd3);
        check("tie.busy", busy4, 0);
        accept4();
        check("tie.accepted", rv4, 0);

        frame4(16'h0400, 16'h0300, 16'h0200, 16'h0100);
        check_res4("desc", 16'h0100, 2'd3, 16'h0200, 2'd2);
        accept4();

        // Wrapped input saturates to 0x7FFF
        frame4(16'h8005, 16'h7000, 16'h7000, 16'h7000);
        check_res4("sat", 16'h7000, 2'd1, 16'h7000, 2'd2);

        // Second frame with no ready: dropped, flagged
        frame4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
        check_res4("drop", 16'h7000, 2'd1, 16'h7000, 2'd2);
        check("drop.ovf", ovf4, 1);
        tick();
        check("drop.hold", mv4, 16'h7000);

        // Ready on the second frame-end: replace, no overflow
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2.ovf", ovf4, 0);
        frame4(16'h0500, 16'h0600, 16'h0700, 16'h0800);
        check_res4("fa", 16'h0500, 2'd0, 16'h0600, 2'd1);
        send4(16'h0050); send4(16'h0040); send4(16'h0030);
        rdy4 = 1'b1;
        send4(16'h0020);
        rdy4 = 1'b0;
        check_res4("fb", 16'h0020, 2'd3, 16'h0030, 2'd2);
        check("fb.ovf", ovf4, 0);
        accept4();

        // frame_clear mid-frame, coincident sample ignored
        send4(16'h0001); send4(16'h0002);
        check("clr.busy_pre", busy4, 1);
        clr4 = 1'b1; dv4 = 1'b1; din4 = 16'h0000;
        tick();
        clr4 = 1'b0; dv4 = 1'b0;
        check("clr.busy", busy4, 0);
        check("clr.valid", rv4, 0);
        frame4(16'h0900, 16'h0800, 16'h0A00, 16'h0800);
        check_res4("clr", 16'h0800, 2'd1, 16'h0800, 2'd3);

        // Reset with a held result and a partial frame
        send4(16'h0111); send4(16'h0222);
        check("rstm.busy_pre", busy4, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstm.valid", rv4, 0);
        check("rstm.min", mv4, 0);
        check("rstm.min_idx", mi4, 0);
        check("rstm.min2", m2v4, 0);
        check("rstm.min2_idx", m2i4, 0);
        check("rstm.busy", busy4, 0);
        check("rstm.ovf", ovf4, 0);
        // Partial data lost: a fresh frame indexes from 0
        frame4(16'h0333, 16'h0444, 16'h0555, 16'h0666);
        check_res4("rstm.after", 16'h0333, 2'd0, 16'h0444, 2'd1);

        // Random back-to-back frames on the 16-candidate instance
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 5) == 0) rv_vals[i] = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                else rv_vals[i] = 16'($urandom_range(0, 7)) << 8;
                dv16 = 1'b1; din16 = rv_vals[i];
                tick();
            end
            dv16 = (f != 3);
            // Lexicographic (value, index) smallest and second smallest
            bi = 0; si = -1;
            for (int i = 1; i < 16; i++) begin
                cond = rv_vals[i][15] ? 16'h7FFF : rv_vals[i];
                if (cond < (rv_vals[bi][15] ? 16'h7FFF : rv_vals[bi])) bi = i;
            end
            for (int i = 0; i < 16; i++) begin
                if (i == bi) continue;
                cond = rv_vals[i][15] ? 16'h7FFF : rv_vals[i];
                if (si < 0) si = i;
                else if (cond < (rv_vals[si][15] ? 16'h7FFF : rv_vals[si])) si = i;
            end
            check("rnd.valid", rv16, 1);
            check("rnd.min", mv16, rv_vals[bi][15] ? 16'h7FFF : rv_vals[bi]);
            check("rnd.min_idx", mi16, bi);
            check("rnd.min2", m2v16, rv_vals[si][15] ? 16'h7FFF : rv_vals[si]);
            check("rnd.min2_idx", m2i16, si);
            check("rnd.ovf", ovf16, 0);
        end
        dv16 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
